request_unit: RTL



---
 rtl/request_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/request_unit.sv
// request_unit: sequencer between the instruction decoder and the memory/cache
// interface. Keeps at most one access (fetch or data) outstanding, registers
// the data read/write requests, pulses pc_en when the PC may advance, and
// raises a sticky halt toward the cache.
//
// Optional feature: define RU_WATCHDOG_EN to build a watchdog that halts the
// core (and sets a sticky wdog_err) when a data access stays outstanding for
// WDOG_LIMIT cycles without dhit. Without the macro, wdog_err is tied 0 and a
// data access waits for dhit indefinitely.
module request_unit #(
  parameter int unsigned WDOG_LIMIT = 255,
  parameter int unsigned CNT_W      = 8
) (
  input  logic CLK,
  input  logic nRST,
  input  logic dREN_in,
  input  logic dWEN_in,
  input  logic halt_in,
  input  logic ihit,
  input  logic dhit,
  output logic imemREN,
  output logic dmemREN,
  output logic dmemWEN,
  output logic pc_en,
  output logic halt,
  output logic busy,
  output logic wdog_err
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  // The watchdog counter must be able to hold WDOG_LIMIT.
  if ((2 ** CNT_W) <= WDOG_LIMIT) begin : g_cfg_check
    $error("request_unit: CNT_W too small for WDOG_LIMIT");
  end

  logic [1:0] state;
  logic       wdog_fire;

  // Fetch requests while waiting for an instruction; data accesses block fetch.
  assign imemREN = (state == FETCH);
  assign busy    = (state == DATA);

  // PC advances on a non-memory, non-halt instruction or on data completion.
  assign pc_en = ((state == FETCH) && ihit && !halt_in && !dWEN_in && !dREN_in)
              || ((state == DATA) && dhit);

`ifdef RU_WATCHDOG_EN
  logic [CNT_W-1:0] wdog_cnt;

  // Timeout when the limit is reached with no completion in the same cycle.
  assign wdog_fire = (state == DATA) && !dhit && (wdog_cnt == CNT_W'(WDOG_LIMIT));

  // Cycle counter for the outstanding data access, plus the sticky error flag.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if ((state == FETCH) && ihit && !halt_in && (dWEN_in || dREN_in)) begin
        wdog_cnt <= '0;
      end else if ((state == DATA) && !dhit && !wdog_fire) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
      if (wdog_fire) begin
        wdog_err <= 1'b1;
      end
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  // Sequencer state and registered memory requests / sticky halt.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!nRST) begin
      state   <= FETCH;
      dmemREN <= 1'b0;
      dmemWEN <= 1'b0;
      halt    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (ihit) begin
            if (halt_in) begin
              state <= HALTED;
              halt  <= 1'b1;
            end else if (dWEN_in) begin
              state   <= DATA;
              dmemWEN <= 1'b1;
              dmemREN <= 1'b0;
            end else if (dREN_in) begin
              state   <= DATA;
              dmemREN <= 1'b1;
              dmemWEN <= 1'b0;
            end
          end
        end
        DATA: begin
          if (dhit) begin
            state   <= FETCH;
            dmemREN <= 1'b0;
            dmemWEN <= 1'b0;
          end else if (wdog_fire) begin
            state   <= HALTED;
            halt    <= 1'b1;
            dmemREN <= 1'b0;
            dmemWEN <= 1'b0;
          end
        end
        HALTED: begin
          halt    <= 1'b1;
          dmemREN <= 1'b0;
          dmemWEN <= 1'b0;
        end
        default: begin
          state   <= FETCH;
          dmemREN <= 1'b0;
          dmemWEN <= 1'b0;
        end
      endcase
    end
  end

endmodule
